// File: rtl/mmio_periph_if.sv
// mmio_periph_if: CPU data-bus slice seen by the MMIO peripheral block.
// master drives sel/addr/memwrite/writedata; slave returns readdata.
interface mmio_periph_if;
  logic        sel;
  logic [31:0] addr;
  logic        memwrite;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output sel, addr, memwrite, writedata,
    input  readdata
  );

  modport slave (
    input  sel, addr, memwrite, writedata,
    output readdata
  );
endinterface

// File: rtl/mmio_periph.sv
// mmio_periph: LED/HEX registers, debounced switches, periodic timer,
// VSYNC frame counter, sticky W1C status and a masked interrupt.
// Ports: clk, reset (async, high), bus (mmio_periph_if.slave),
//   sw (raw switches), vsync_n (async VSYNC), ledr, hex_digits, irq.
module mmio_periph #(
  parameter int LED_W    = 10,
  parameter int NUM_HEX  = 6,
  parameter int SW_W     = 10,
  parameter int DEBOUNCE = 16,
  parameter int FRAME_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_periph_if.slave         bus,
  input  logic [SW_W-1:0]      sw,
  input  logic                 vsync_n,
  output logic [LED_W-1:0]     ledr,
  output logic [4*NUM_HEX-1:0] hex_digits,
  output logic                 irq
);

  localparam int HEX_W = 4 * NUM_HEX;
  localparam int CNT_W =
    (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    R_STATUS = 3'd0,
    R_LEDS   = 3'd1,
    R_HEX    = 3'd2,
    R_SW     = 3'd3,
    R_TIMER  = 3'd4,
    R_FRAME  = 3'd5,
    R_MASK   = 3'd6,
    R_NONE   = 3'd7
  } reg_e;

  reg_e        idx;
  logic        wr_en;
  logic [31:0] wdata;
  logic        unused_ok;

  assign idx       = reg_e'(bus.addr[4:2]);
  assign wr_en     = bus.sel & bus.memwrite;
  assign wdata     = bus.writedata;
  assign unused_ok = ^{bus.addr[31:5], bus.addr[1:0]};

  logic wr_status, wr_leds, wr_hex;
  logic wr_timer, wr_frame, wr_mask;

  assign wr_status = wr_en && (idx == R_STATUS);
  assign wr_leds   = wr_en && (idx == R_LEDS);
  assign wr_hex    = wr_en && (idx == R_HEX);
  assign wr_timer  = wr_en && (idx == R_TIMER);
  assign wr_frame  = wr_en && (idx == R_FRAME);
  assign wr_mask   = wr_en && (idx == R_MASK);

  // Plain read/write registers
  logic [LED_W-1:0] led_q, led_d;
  logic [HEX_W-1:0] hex_q, hex_d;
  logic [2:0]       mask_q, mask_d;
  logic [2:0]       status_q, status_d;

  // Switch path
  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [SW_W-1:0]  sw_q, sw_d;
  logic [CNT_W-1:0] db_q, db_d;
  logic             set_sw;

  // Frame path
  logic               vs_s1_q, vs_s2_q, vs_prev_q;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               vs_fall;

  // Timer
  logic        tmr_en_q, tmr_en_d;
  logic [31:0] tmr_cnt_q, tmr_cnt_d;
  logic [31:0] tmr_rld_q, tmr_rld_d;
  logic        set_tmr;

  logic [2:0]  clr_mask;
  logic [31:0] rdata;

  always_comb begin
    led_d  = led_q;
    hex_d  = hex_q;
    mask_d = mask_q;
    if (wr_leds) led_d = wdata[LED_W-1:0];
    if (wr_hex)  hex_d = wdata[HEX_W-1:0];
    if (wr_mask) mask_d = wdata[2:0];
  end

  // A change landing in the second sync flop restarts the
  // count, so the window only covers a settled value.
  always_comb begin
    sw_d   = sw_q;
    db_d   = db_q;
    set_sw = 1'b0;
    if (sw_s1_q != sw_s2_q) begin
      db_d = '0;
    end else if (sw_s2_q != sw_q) begin
      if (db_q == CNT_MAX) begin
        sw_d   = sw_s2_q;
        db_d   = '0;
        set_sw = 1'b1;
      end else begin
        db_d = db_q + CNT_W'(1);
      end
    end else begin
      db_d = '0;
    end
  end

  // Edge detect sits behind the synchroniser: 3-cycle latency.
  assign vs_fall = vs_prev_q & ~vs_s2_q;

  always_comb begin
    frame_d = frame_q;
    if (wr_frame) begin
      frame_d = '0;
    end else if (vs_fall) begin
      frame_d = frame_q + FRAME_W'(1);
    end
  end

  // A TIMER write overrides a coincident expiry.
  always_comb begin
    tmr_en_d  = tmr_en_q;
    tmr_cnt_d = tmr_cnt_q;
    tmr_rld_d = tmr_rld_q;
    set_tmr   = 1'b0;
    if (wr_timer) begin
      if (wdata != 32'd0) begin
        tmr_en_d  = 1'b1;
        tmr_cnt_d = wdata;
        tmr_rld_d = wdata;
      end else begin
        tmr_en_d  = 1'b0;
        tmr_cnt_d = '0;
        tmr_rld_d = '0;
      end
    end else if (tmr_en_q) begin
      if (tmr_cnt_q == 32'd1) begin
        tmr_cnt_d = tmr_rld_q;
        set_tmr   = 1'b1;
      end else begin
        tmr_cnt_d = tmr_cnt_q - 32'd1;
      end
    end
  end

  // New events are OR-ed in after the clear, so set wins.
  always_comb begin
    clr_mask = wr_status ? wdata[2:0] : 3'b000;
    status_d = (status_q & ~clr_mask)
             | {set_tmr, vs_fall, set_sw};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q     <= '0;
      hex_q     <= '0;
      mask_q    <= '0;
      status_q  <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_q      <= '0;
      db_q      <= '0;
      vs_s1_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      vs_prev_q <= 1'b0;
      frame_q   <= '0;
      tmr_en_q  <= 1'b0;
      tmr_cnt_q <= '0;
      tmr_rld_q <= '0;
    end else begin
      led_q     <= led_d;
      hex_q     <= hex_d;
      mask_q    <= mask_d;
      status_q  <= status_d;
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      sw_q      <= sw_d;
      db_q      <= db_d;
      vs_s1_q   <= vsync_n;
      vs_s2_q   <= vs_s1_q;
      vs_prev_q <= vs_s2_q;
      frame_q   <= frame_d;
      tmr_en_q  <= tmr_en_d;
      tmr_cnt_q <= tmr_cnt_d;
      tmr_rld_q <= tmr_rld_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.sel) begin
      unique case (idx)
        R_STATUS: rdata[2:0] = status_q;
        R_LEDS:   rdata[LED_W-1:0] = led_q;
        R_HEX:    rdata[HEX_W-1:0] = hex_q;
        R_SW:     rdata[SW_W-1:0] = sw_q;
        R_TIMER:  rdata = tmr_cnt_q;
        R_FRAME:  rdata[FRAME_W-1:0] = frame_q;
        R_MASK:   rdata[2:0] = mask_q;
        R_NONE:   rdata = '0;
      endcase
    end
  end

  assign bus.readdata = rdata;
  assign ledr         = led_q;
  assign hex_digits   = hex_q;
  assign irq          = |(status_q & mask_q);

endmodule

// File: tb/tb_mmio_periph.sv
// tb_mmio_periph: directed stimulus with a cycle-level reference
// model of the register map, compared on every clock.
module tb_mmio_periph;
  localparam int D   = 4;
  localparam int FW  = 2;
  localparam int LW  = 10;
  localparam int NH  = 6;
  localparam int SWW = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [SWW-1:0] sw = '0;
  logic           vsync_n = 1'b1;
  logic [LW-1:0]  ledr;
  logic [4*NH-1:0] hex_digits;
  logic           irq;

  mmio_periph_if bus();

  mmio_periph #(
    .LED_W(LW), .NUM_HEX(NH), .SW_W(SWW),
    .DEBOUNCE(D), .FRAME_W(FW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .sw(sw),
    .vsync_n(vsync_n),
    .ledr(ledr),
    .hex_digits(hex_digits),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: state as the register map describes it.
  logic [LW-1:0]   m_led;
  logic [4*NH-1:0] m_hex;
  logic [2:0]      m_mask, m_st, m_set, m_clr;
  logic [SWW-1:0]  m_sw;
  logic [FW-1:0]   m_frame;
  bit              m_en, m_stable;
  longint          m_next, m_per, cyc;
  logic [31:0]     m_wd;
  logic [SWW-1:0]  swq[$];
  logic            vq[$];

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_led = '0; m_hex = '0; m_mask = '0; m_st = '0;
      m_sw = '0; m_frame = '0; m_en = 0;
      m_next = 0; m_per = 0; cyc = 0;
      swq = {};
      for (int i = 0; i <= D; i++) swq.push_back('0);
      vq = {1'b0, 1'b0, 1'b0};
    end else begin
      cyc++;
      m_set = '0;
      m_clr = '0;
      // accept once the last D+1 synchronised samples agree
      m_stable = 1;
      foreach (swq[i]) if (swq[i] != swq[0]) m_stable = 0;
      if (m_stable && swq[0] != m_sw) begin
        m_sw = swq[0];
        m_set[0] = 1'b1;
      end
      swq.push_back(sw);
      void'(swq.pop_front());
      // vq[0], vq[1]: samples 3 and 2 edges ago
      if (vq[0] == 1'b1 && vq[1] == 1'b0) begin
        m_frame = m_frame + 1'b1;
        m_set[1] = 1'b1;
      end
      vq.push_back(vsync_n);
      void'(vq.pop_front());
      if (m_en && cyc == m_next) begin
        m_set[2] = 1'b1;
        m_next = m_next + m_per;
      end
      if (bus.sel && bus.memwrite) begin
        m_wd = bus.writedata;
        case (bus.addr[4:2])
          3'd0: m_clr = m_wd[2:0];
          3'd1: m_led = m_wd[LW-1:0];
          3'd2: m_hex = m_wd[4*NH-1:0];
          3'd4: begin
            m_set[2] = 1'b0;
            m_en = (m_wd != 32'd0);
            m_per = longint'(m_wd);
            m_next = cyc + longint'(m_wd);
          end
          3'd5: m_frame = '0;
          3'd6: m_mask = m_wd[2:0];
          default: ;
        endcase
      end
      m_st = (m_st & ~m_clr) | m_set;
    end
  end

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = '0;
    if (bus.sel) begin
      case (bus.addr[4:2])
        3'd0: r[2:0] = m_st;
        3'd1: r[LW-1:0] = m_led;
        3'd2: r[4*NH-1:0] = m_hex;
        3'd3: r[SWW-1:0] = m_sw;
        3'd4: r = m_en ? 32'(m_next - cyc) : 32'd0;
        3'd5: r[FW-1:0] = m_frame;
        3'd6: r[2:0] = m_mask;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    chk("cyc_ledr", 32'(ledr), 32'(m_led));
    chk("cyc_hex", 32'(hex_digits), 32'(m_hex));
    chk("cyc_irq", 32'(irq), 32'(|(m_st & m_mask)));
    chk("cyc_rd", bus.readdata, exp_rd());
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1;
    bus.memwrite = 1'b1;
    bus.addr = a;
    bus.writedata = d;
    @(negedge clk);
    bus.memwrite = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a,
                    input logic [31:0] exp);
    @(negedge clk);
    bus.sel = 1'b1;
    bus.memwrite = 1'b0;
    bus.addr = a;
    #1;
    chk(nm, bus.readdata, exp);
  endtask

  task automatic vpulse();
    @(negedge clk);
    vsync_n = 1'b0;
    repeat (3) @(negedge clk);
    vsync_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.sel = 1'b0;
    bus.memwrite = 1'b0;
    bus.addr = '0;
    bus.writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ledr", 32'(ledr), 32'h0);
    chk("rst_hex", 32'(hex_digits), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 8; i++)
      rd("rst_rd", 32'h100 + 32'(4 * i), 32'h0);

    // LED / HEX
    wr(32'h104, 32'h3FF);
    chk("led_out", 32'(ledr), 32'h3FF);
    rd("led_rb", 32'h104, 32'h3FF);
    wr(32'h108, 32'h123456);
    chk("hex_out", 32'(hex_digits), 32'h123456);
    rd("hex_rb", 32'h108, 32'h123456);
    @(negedge clk);
    bus.sel = 1'b0;
    bus.memwrite = 1'b1;
    bus.addr = 32'h104;
    bus.writedata = 32'h0;
    #1;
    chk("nosel_rd", bus.readdata, 32'h0);
    @(negedge clk);
    bus.memwrite = 1'b0;
    chk("nosel_led", 32'(ledr), 32'h3FF);

    // switches: 2 sync + D debounce cycles
    @(negedge clk);
    bus.sel = 1'b1;
    bus.addr = 32'h10C;
    sw = 10'h005;
    repeat (5) @(posedge clk);
    #1 chk("sw_e5", bus.readdata, 32'h0);
    @(posedge clk);
    #1 chk("sw_e6", bus.readdata, 32'h5);
    rd("swchg", 32'h100, 32'h1);
    @(negedge clk);
    sw = 10'h007;
    repeat (2) @(negedge clk);
    sw = 10'h005;
    repeat (10) @(negedge clk);
    rd("glitch_sw", 32'h10C, 32'h5);
    rd("glitch_st", 32'h100, 32'h1);
    wr(32'h100, 32'h1);
    rd("w1c_sw", 32'h100, 32'h0);

    // timer, period 5, TMR unmasked
    wr(32'h118, 32'h4);
    wr(32'h110, 32'h5);
    repeat (4) @(posedge clk);
    #1 chk("tmr_e4_irq", 32'(irq), 32'h0);
    chk("tmr_e4_cnt", bus.readdata, 32'h1);
    @(posedge clk);
    #1 chk("tmr_e5_irq", 32'(irq), 32'h1);
    chk("tmr_e5_cnt", bus.readdata, 32'h5);
    // clear lands on the edge-10 expiry
    repeat (4) @(posedge clk);
    wr(32'h100, 32'h4);
    rd("tmr_race", 32'h100, 32'h4);
    wr(32'h100, 32'h4);
    rd("tmr_clr", 32'h100, 32'h0);
    chk("tmr_clr_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1 chk("tmr_e15_irq", 32'(irq), 32'h1);
    wr(32'h110, 32'h0);
    rd("tmr_off", 32'h110, 32'h0);
    wr(32'h100, 32'h4);
    rd("tmr_off_st", 32'h100, 32'h0);

    // frame counter, FW = 2
    @(negedge clk);
    bus.sel = 1'b1;
    bus.addr = 32'h114;
    vsync_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("frm_e2", bus.readdata, 32'h0);
    @(posedge clk);
    #1 chk("frm_e3", bus.readdata, 32'h1);
    @(negedge clk);
    @(negedge clk);
    vsync_n = 1'b1;
    repeat (4) @(negedge clk);
    vpulse();
    vpulse();
    rd("frm_3", 32'h114, 32'h3);
    rd("frm_flag", 32'h100, 32'h2);
    wr(32'h114, 32'h0);
    rd("frm_clr", 32'h114, 32'h0);
    for (int i = 0; i < 5; i++) vpulse();
    rd("frm_wrap", 32'h114, 32'h1);

    // asynchronous reset in the middle of a count
    wr(32'h110, 32'h7);
    repeat (9) @(negedge clk);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    bus.sel = 1'b1;
    bus.addr = 32'h110;
    #2 reset = 1'b1;
    #1;
    chk("arst_ledr", 32'(ledr), 32'h0);
    chk("arst_hex", 32'(hex_digits), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_cnt", bus.readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_periph.md
# mmio_periph

Parametrised memory-mapped peripheral block for the RISC-V/VGA system. It sits on the CPU data bus at base 0x0000_0100, with select driven by `addr[8]`. It replaces write-only LED/HEX decoding with a readable register file, debounced switches, a periodic timer, VSYNC frame counting, sticky status flags and a masked interrupt line. All outputs are registered except `readdata` and `irq`.

## Interface
- `LED_W`, default 10: LED register width.
- `NUM_HEX`, default 6: HEX digits; HEX register is 4*NUM_HEX bits.
- `SW_W`, default 10: switch input width.
- `DEBOUNCE`, default 16: cycles a synchronised switch value must stay stable before it is accepted (≥1).
- `FRAME_W`, default 16: frame counter width.

Ports:
- `clk`  in  1: system clock (CPU clock).
- `reset`  in  1: asynchronous, active-high reset.
- `sel`  in  1: I/O region selected.
- `addr`  in  32: byte address; only `addr[4:2]` is decoded.
- `memwrite`  in  1: write strobe, qualified by `sel`.
- `writedata`  in  32: write data.
- `readdata`  out  32: combinational read data.
- `sw`  in  SW_W: raw asynchronous switches.
- `vsync_n`  in  1: VGA VSYNC (active low, from VGA_CLK domain).
- `ledr`  out  LED_W: LED register.
- `hex_digits`  out  4*NUM_HEX: HEX register, nibble i drives digit i.
- `irq`  out  1: |(STATUS & MASK).

## Operation
Register map (word index `addr[4:2]`, offset from 0x100):
- 0 STATUS 0x100: bit0 SWCHG, bit1 FRAME, bit2 TMR. Write-1-to-clear. Other bits read 0.
- 1 LEDS 0x104: read/write, low LED_W bits.
- 2 HEX 0x108: read/write, low 4*NUM_HEX bits.
- 3 SW 0x10C: read-only, debounced switch value.
- 4 TIMER 0x110: write loads period P. Reads return the current down-count.
- 5 FRAME 0x114: read-only frame count. Any write clears it to 0.
- 6 MASK 0x118: read/write, bits[2:0].
- 7: reads 0, writes ignored.

Reads and writes:
- `readdata` is 0 when `sel`=0. Unused upper bits are 0.
- A write is performed at posedge `clk` when `sel & memwrite`.

Switches:
- Two-flop synchroniser, then a stability counter.
- When the synchronised value differs from SW, the counter increments. It resets whenever the synchronised value changes.
- When the counter reaches DEBOUNCE-1, SW takes the synchronised value and SWCHG is set.

Frame counter:
- Two-flop synchroniser on `vsync_n`.
- A falling edge (sync level 1→0) increments FRAME (wraps modulo 2^FRAME_W) and sets the FRAME flag.

Timer:
- A write of P≠0 sets count=P and reload=P, enabling the timer. A write of P=0 disables it with count=0.
- While enabled, count decrements each cycle.
- When count=1, the next value is reload and TMR is set. Period is P cycles.

Flag and write precedence:
- Same-cycle set and W1C on a flag: set wins.
- TIMER write in the same cycle as expiry: the write wins and TMR is not set.

## Timing
- Reset values: `ledr`, `hex_digits`, SW, STATUS, MASK, FRAME, timer count/reload/enable, synchronisers and debounce counter are all 0. `irq`=0.
- Writes become visible on `ledr`, `hex_digits` and in readback the cycle after the write edge.
- Switch latency:
  - SW updates 2 + DEBOUNCE cycles after a stable change appears at `sw`.
  - SWCHG is set in the same cycle SW updates.
- FRAME latency: the frame count and flag update 3 cycles after the `vsync_n` falling edge reaches `clk`.
- TMR: a write of P at edge 0 sets TMR at edge P, and every P edges thereafter.
- `irq` is combinational from registered STATUS and MASK, so it has no extra latency.
- A reset mid-operation clears everything immediately, independent of `clk`.

## Test plan
- Reset then read all 8 words -> all read 0. `ledr`=0, `hex_digits`=0, `irq`=0.
- Write 0x3FF to 0x104 and 0x123456 to 0x108 -> `ledr`=0x3FF and `hex_digits`=0x123456 next cycle. Readback matches. Write with `sel`=0 -> no change.
- DEBOUNCE=4, `sw` 0→0x005 held -> SW reads 0x005 exactly 6 cycles later and STATUS bit0=1. A 2-cycle glitch -> no update. Write 0x1 to 0x100 -> bit0 cleared.
- Write 5 to 0x110, MASK=0x4 -> TMR and `irq` assert at cycles 5, 10, 15. Write 0 -> the timer stops and count reads 0.
- Three `vsync_n` low pulses -> FRAME reads 3 and bit1 is set. With FRAME_W=2 and five pulses -> reads 1.
- Corner cases:
  - W1C of TMR in the same cycle as expiry -> TMR stays 1.
  - Reset asserted mid-count -> all state is 0 without a clock edge.
